// File: rtl/zxuno_regport_arbiter.sv
// Register-port arbiter: shares the IOADDR/IODATA pair between the Z80 and
// one auxiliary master. Each aux access is an address write, then a data
// read or write, then a rewrite of the CPU's last selected register address.
// This keeps aux traffic invisible to CPU software.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | CPU passthrough; shadow tracks CPU writes to IOADDR
//   A_ADDR | aux writes target register number to IOADDR
//   A_GAP1 | all strobes released
//   A_DATA | aux reads or writes IODATA
//   A_GAP2 | all strobes released
//   A_REST | aux rewrites the CPU's shadowed register number to IOADDR
//   A_GAP3 | all strobes released; aux_ack is asserted on the next edge
module zxuno_regport_arbiter #(
    parameter logic [15:0] IOADDR = 16'hFC3B,
    parameter logic [15:0] IODATA = 16'hFD3B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_wait_n,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [7:0]  aux_addr,
    input  logic [7:0]  aux_wdata,
    output logic        aux_ack,
    output logic [7:0]  aux_rdata,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [15:0] rp_a,
    output logic        rp_iorq_n,
    output logic        rp_rd_n,
    output logic        rp_wr_n,
    output logic [7:0]  rp_din
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_ADDR = 3'd1,
        A_GAP1 = 3'd2,
        A_DATA = 3'd3,
        A_GAP2 = 3'd4,
        A_REST = 3'd5,
        A_GAP3 = 3'd6
    } state_t;

    state_t     state;
    logic       lat_we;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;
    logic [7:0] shadow;
    logic       cpu_zx;

    assign cpu_zx = !cpu_iorq_n && ((cpu_a == IOADDR) || (cpu_a == IODATA));
    assign busy   = (state != IDLE);

    // Sequencer: accepts aux requests in IDLE (CPU wins collisions), walks the fixed sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
            shadow    <= 8'h00;
            aux_rdata <= 8'h00;
            aux_ack   <= 1'b0;
        end else begin
            aux_ack <= (state == A_GAP3);
            case (state)
                IDLE: begin
                    if (!cpu_iorq_n && !cpu_wr_n && (cpu_a == IOADDR))
                        shadow <= cpu_dout;
                    // The ack cycle blocks acceptance so a held request cannot restart at once.
                    if (aux_req && !cpu_zx && !aux_ack) begin
                        lat_we    <= aux_we;
                        lat_addr  <= aux_addr;
                        lat_wdata <= aux_wdata;
                        state     <= A_ADDR;
                    end
                end
                A_ADDR: state <= A_GAP1;
                A_GAP1: state <= A_DATA;
                A_DATA: begin
                    if (!lat_we)
                        aux_rdata <= reg_rdata;
                    state <= A_GAP2;
                end
                A_GAP2: state <= A_REST;
                A_REST: state <= A_GAP3;
                A_GAP3: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux: CPU passthrough in IDLE, otherwise aux-driven cycles with CPU ZX accesses stalled.
    always_comb begin
        rp_a       = cpu_a;
        rp_iorq_n  = cpu_iorq_n;
        rp_rd_n    = cpu_rd_n;
        rp_wr_n    = cpu_wr_n;
        rp_din     = cpu_dout;
        cpu_wait_n = 1'b1;
        if (state != IDLE) begin
            rp_a       = 16'h0000;
            rp_iorq_n  = 1'b1;
            rp_rd_n    = 1'b1;
            rp_wr_n    = 1'b1;
            rp_din     = 8'h00;
            cpu_wait_n = !cpu_zx;
        end
        case (state)
            A_ADDR: begin
                rp_a      = IOADDR;
                rp_iorq_n = 1'b0;
                rp_wr_n   = 1'b0;
                rp_din    = lat_addr;
            end
            A_DATA: begin
                rp_a      = IODATA;
                rp_iorq_n = 1'b0;
                if (lat_we) begin
                    rp_wr_n = 1'b0;
                    rp_din  = lat_wdata;
                end else begin
                    rp_rd_n = 1'b0;
                end
            end
            A_REST: begin
                rp_a      = IOADDR;
                rp_iorq_n = 1'b0;
                rp_wr_n   = 1'b0;
                rp_din    = shadow;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_zxuno_regport_arbiter.sv
// Directed bench for zxuno_regport_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, expected values are hand-computed.
module tb_zxuno_regport_arbiter;

    localparam logic [15:0] IOADDR = 16'hFC3B;
    localparam logic [15:0] IODATA = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic        cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_dout;
    logic        cpu_wait_n;
    logic        aux_req, aux_we;
    logic [7:0]  aux_addr, aux_wdata;
    logic        aux_ack;
    logic [7:0]  aux_rdata;
    logic [7:0]  reg_rdata;
    logic        busy;
    logic [15:0] rp_a;
    logic        rp_iorq_n, rp_rd_n, rp_wr_n;
    logic [7:0]  rp_din;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    zxuno_regport_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_a      (cpu_a),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_ack    (aux_ack),
        .aux_rdata  (aux_rdata),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .rp_a       (rp_a),
        .rp_iorq_n  (rp_iorq_n),
        .rp_rd_n    (rp_rd_n),
        .rp_wr_n    (rp_wr_n),
        .rp_din     (rp_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_a      = 16'h0000;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_dout   = 8'h00;
    endtask

    // Walks the seven cycles after an accepting edge; returns at the ack cycle (+1 ns).
    task automatic aux_phases(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rest, input logic [7:0] rdata);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            case (k)
                1: begin
                    chk("addr_busy", busy, 1);
                    chk("addr_a", rp_a, IOADDR);
                    chk("addr_iorq", rp_iorq_n, 0);
                    chk("addr_wr", rp_wr_n, 0);
                    chk("addr_rd", rp_rd_n, 1);
                    chk("addr_din", rp_din, addr);
                end
                2, 4, 6: begin
                    chk("gap_a", rp_a, 0);
                    chk("gap_iorq", rp_iorq_n, 1);
                    chk("gap_rd", rp_rd_n, 1);
                    chk("gap_wr", rp_wr_n, 1);
                    chk("gap_din", rp_din, 0);
                    chk("gap_ack", aux_ack, 0);
                end
                3: begin
                    chk("data_a", rp_a, IODATA);
                    chk("data_iorq", rp_iorq_n, 0);
                    chk("data_wr", rp_wr_n, we ? 0 : 1);
                    chk("data_rd", rp_rd_n, we ? 1 : 0);
                    if (we) chk("data_din", rp_din, wdata);
                end
                5: begin
                    chk("rest_a", rp_a, IOADDR);
                    chk("rest_iorq", rp_iorq_n, 0);
                    chk("rest_wr", rp_wr_n, 0);
                    chk("rest_din", rp_din, rest);
                end
                default: begin
                    chk("ack_pulse", aux_ack, 1);
                    chk("ack_busy", busy, 0);
                    if (!we) chk("ack_rdata", aux_rdata, rdata);
                end
            endcase
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_idle();
        aux_req   = 1'b0;
        aux_we    = 1'b0;
        aux_addr  = 8'h00;
        aux_wdata = 8'h00;
        reg_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wait", cpu_wait_n, 1);
        chk("rst_ack", aux_ack, 0);
        chk("rst_rdata", aux_rdata, 8'h00);

        // 1: CPU OUT FC3B,05 in passthrough, then aux read of reg 40.
        @(negedge clk);
        cpu_a = IOADDR; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; cpu_dout = 8'h05;
        #1;
        chk("t1_pass_a", rp_a, IOADDR);
        chk("t1_pass_wr", rp_wr_n, 0);
        chk("t1_pass_din", rp_din, 8'h05);
        @(negedge clk);
        cpu_idle();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h40; reg_rdata = 8'h9A;
        aux_phases(1'b0, 8'h40, 8'h00, 8'h05, 8'h9A);
        aux_req = 1'b0;
        @(negedge clk); #1;
        chk("t1_ack_once", aux_ack, 0);

        // 2: aux write 0B<-55; restore uses shadow 05; aux_rdata held.
        reg_rdata = 8'h11;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h0B; aux_wdata = 8'h55;
        aux_phases(1'b1, 8'h0B, 8'h55, 8'h05, 8'h00);
        chk("t2_rdata_held", aux_rdata, 8'h9A);
        aux_req = 1'b0;
        @(negedge clk);

        // 3: CPU IN FD3B collides with aux_req; CPU completes first.
        cpu_a = IODATA; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h22; aux_wdata = 8'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_cpu_first_busy", busy, 0);
            chk("t3_cpu_rd", rp_rd_n, 0);
            chk("t3_cpu_wait", cpu_wait_n, 1);
            @(negedge clk);
        end
        cpu_idle();
        aux_phases(1'b1, 8'h22, 8'h33, 8'h05, 8'h00);
        aux_req = 1'b0;
        @(negedge clk);

        // 4: CPU OUT FC3B,C4 during A_DATA is stalled and masked.
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h01; aux_wdata = 8'h77;
        repeat (3) @(negedge clk);
        cpu_a = IOADDR; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; cpu_dout = 8'hC4;
        #1;
        chk("t4_wait_data", cpu_wait_n, 0);
        chk("t4_mask_a", rp_a, IODATA);
        chk("t4_mask_din", rp_din, 8'h77);
        @(negedge clk); #1;
        chk("t4_wait_gap", cpu_wait_n, 0);
        chk("t4_mask_wr", rp_wr_n, 1);
        @(negedge clk); #1;
        chk("t4_rest_old_shadow", rp_din, 8'h05);
        @(negedge clk); #1;
        chk("t4_wait_gap3", cpu_wait_n, 0);
        @(negedge clk); #1;
        chk("t4_ack", aux_ack, 1);
        chk("t4_released", cpu_wait_n, 1);
        chk("t4_pass_din", rp_din, 8'hC4);
        chk("t4_pass_wr", rp_wr_n, 0);
        aux_req = 1'b0;
        @(negedge clk);
        cpu_idle();
        // Non-ZX CPU I/O during busy is never waited.
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h50; reg_rdata = 8'h66;

        // 5: held request; restore shows shadow C4; next start one cycle after the ack cycle.
        aux_phases(1'b0, 8'h50, 8'h00, 8'hC4, 8'h66);
        acks = 0;
        for (int k = 8; k <= 14; k++) begin
            @(negedge clk); #1;
            if (aux_ack) acks++;
            if (k == 8) chk("t5_idle_gap", busy, 0);
            if (k == 9) chk("t5_restart", busy, 1);
            if (k == 10) begin
                cpu_a = 16'h00FE; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
                #1;
                chk("t5_nonzx_nowait", cpu_wait_n, 1);
                cpu_idle();
            end
        end
        chk("t5_no_extra_ack", acks, 0);
        @(negedge clk); #1;
        chk("t5_second_ack", aux_ack, 1);
        aux_req = 1'b0;
        @(negedge clk);

        // 6: reset during A_DATA aborts without ack.
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h02; aux_wdata = 8'h88;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_in_data", rp_a, IODATA);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; aux_req = 1'b0;
        cpu_a = 16'h1234; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ack", aux_ack, 0);
        chk("t6_wait", cpu_wait_n, 1);
        chk("t6_rdata", aux_rdata, 8'h00);
        chk("t6_pass_a", rp_a, 16'h1234);
        chk("t6_pass_rd", rp_rd_n, 0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (aux_ack) acks++;
        end
        chk("t6_never_acked", acks, 0);
        cpu_idle();
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h03; aux_wdata = 8'hA5;
        aux_phases(1'b1, 8'h03, 8'hA5, 8'h00, 8'h00);
        aux_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
